// File: rtl/jt12_i2s_tx.sv
// Stereo I2S transmitter: buffers one left/right frame from the output
// amplifier and serializes it MSB first with a one-slot data lag behind LRCK.
// BCLK/LRCK/SDATA are derived from clk through a DIV-cycle half-period divider.
// Overrun/underrun pulses report sample-rate mismatch with the frame rate.
module jt12_i2s_tx #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        overrun,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [7:0]  div;
  logic [4:0]  slot;
  logic [31:0] shreg;
  logic [15:0] hold_l;
  logic [15:0] hold_r;
  logic        pending;

  logic        edge_cyc;
  logic        fall_cyc;
  logic        load;
  logic [4:0]  slot_nxt;

  // Edge, falling-edge and frame-load qualifiers for this cycle
  always_comb begin
    edge_cyc = (div == DIV_LAST);
    fall_cyc = edge_cyc & bclk;
    slot_nxt = slot + 5'd1;
    load     = fall_cyc && (slot_nxt == 5'd1);
  end

  // Bit clock divider: toggle bclk every DIV system clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (edge_cyc) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 8'd1;
    end
  end

  // Frame serializer: advance slot, drive word select and data on bclk fall.
  // Shifting through slot 0 naturally presents the previous frame's LSB,
  // which gives the one-slot I2S data lag without extra storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot  <= '0;
      lrck  <= 1'b0;
      sdata <= 1'b0;
      shreg <= '0;
    end else if (fall_cyc) begin
      slot <= slot_nxt;
      lrck <= slot_nxt[4];
      if (slot_nxt == 5'd1) begin
        shreg <= {hold_l, hold_r};
        sdata <= hold_l[15];
      end else begin
        shreg <= {shreg[30:0], 1'b0};
        sdata <= shreg[30];
      end
    end
  end

  // Holding register and flow flags; a load in the same cycle as a strobe
  // takes the old hold contents while the new sample stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l   <= '0;
      hold_r   <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
      if (sample) begin
        hold_l <= left;
        hold_r <= right;
      end
      if (load && !pending)
        underrun <= 1'b1;
      if (sample && pending && !load)
        overrun <= 1'b1;
      if (sample)
        pending <= 1'b1;
      else if (load)
        pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Bench for jt12_i2s_tx: every cycle is compared against a frame-level model
// computed from the cycle index since reset and the list of accepted samples.
module tb_jt12_i2s_tx;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample = 1'b0;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  logic        bclk, lrck, sdata, overrun, underrun;

  jt12_i2s_tx #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .sample(sample), .left(left), .right(right),
    .bclk(bclk), .lrck(lrck), .sdata(sdata),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] l;
    logic [15:0] r;
  } smp_t;

  typedef struct {
    int   slot;
    logic sd;
    logic lr;
  } vec_t;

  smp_t sq[$];
  int   n = 0;
  int   checks = 0;
  int   fails = 0;
  int   ucount = 0;
  int   ocount = 0;

  // ---------------- reference model ----------------
  function automatic int loads_upto(int x);
    if (x < 2 * DIV) return 0;
    return (x - 2 * DIV) / (64 * DIV) + 1;
  endfunction

  // Frame m carries the latest sample accepted strictly before its load cycle
  function automatic logic [31:0] frame_of(int m);
    int          nl;
    logic [31:0] f;
    nl = 2 * DIV * (1 + 32 * m);
    f  = '0;
    foreach (sq[i]) if (sq[i].idx < nl) f = {sq[i].l, sq[i].r};
    return f;
  endfunction

  function automatic logic exp_under(int t);
    int   lo, m;
    logic none;
    if (t < 1 || loads_upto(t) == loads_upto(t - 1)) return 1'b0;
    m    = loads_upto(t) - 1;
    lo   = (m == 0) ? 0 : 2 * DIV * (1 + 32 * (m - 1));
    none = 1'b1;
    foreach (sq[i]) if (sq[i].idx >= lo && sq[i].idx < t) none = 1'b0;
    return none;
  endfunction

  function automatic logic exp_over(int t);
    int p;
    if (sq.size() < 2) return 1'b0;
    if (sq[sq.size() - 1].idx != t) return 1'b0;
    p = sq[sq.size() - 2].idx;
    return loads_upto(t) == loads_upto(p);
  endfunction

  function automatic logic [4:0] exp_out(int t);
    int          k, s;
    logic [31:0] f, fs;
    logic        b, l, sd;
    k  = t / (2 * DIV);
    s  = k % 32;
    b  = ((t / DIV) % 2) == 1;
    l  = s >= 16;
    sd = 1'b0;
    if (k > 0) begin
      if (s != 0) begin
        f  = frame_of((k - 1) / 32);
        fs = f >> (32 - s);
      end else begin
        f  = frame_of(k / 32 - 1);
        fs = f;
      end
      sd = fs[0];
    end
    return {b, l, sd, exp_over(t), exp_under(t)};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Advance one clock: record what the DUT accepted, then compare at negedge
  task automatic tick();
    smp_t       s;
    logic [4:0] e;
    @(posedge clk);
    if (rst) begin
      n = 0;
      sq.delete();
    end else begin
      n = n + 1;
      if (sample) begin
        s.idx = n;
        s.l   = left;
        s.r   = right;
        sq.push_back(s);
      end
    end
    @(negedge clk);
    e = exp_out(n);
    checks++;
    if ({bclk, lrck, sdata, overrun, underrun} !== e) begin
      fails++;
      $display("FAIL model n=%0d: got {bclk,lrck,sdata,ovr,udr}=%b expected %b",
               n, {bclk, lrck, sdata, overrun, underrun}, e);
    end
    if (underrun) ucount++;
    if (overrun) ocount++;
  endtask

  task automatic wait_until(input int t);
    int guard = 0;
    while (n < t && guard < 100000) begin
      tick();
      guard++;
    end
    chk("wait_until", 32'(n), 32'(t));
  endtask

  task automatic strobe_at(input int idx, input logic [15:0] l, input logic [15:0] r);
    wait_until(idx - 1);
    sample = 1'b1;
    left   = l;
    right  = r;
    tick();
    sample = 1'b0;
  endtask

  task automatic capture(input int m, output logic [31:0] f);
    int k;
    f = '0;
    for (int s = 1; s <= 32; s++) begin
      k = 32 * m + s;
      wait_until(2 * DIV * k);
      if (s < 32) f[32 - s] = sdata;
      else        f[0] = sdata;
    end
  endtask

  task automatic check_restart(input string tag);
    int cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bclk && cnt < 4 * DIV);
    chk({tag, "_first_rise"}, 32'(cnt), 32'(DIV));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at n=%0d", n);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t        tab[32];
    logic [31:0] pat, ps, f;
    logic [15:0] r1, r2, r3, r4;
    logic        prev;
    int          guard, k, kk;

    pat = 32'b1000_0000_0000_0001_0111_1111_1111_1110;
    for (int i = 0; i < 32; i++) begin
      ps          = pat >> (31 - i);
      tab[i].slot = (i + 1) % 32;
      tab[i].sd   = ps[0];
      tab[i].lr   = ((i + 1) % 32) >= 16;
    end

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample = 1'($urandom);
      left   = 16'($urandom);
      right  = 16'($urandom);
      tick();
    end
    chk("reset_outputs", 32'({bclk, lrck, sdata, overrun, underrun}), 32'(0));
    sample = 1'b0;
    rst    = 1'b0;
    check_restart("reset");

    // Single known frame, strobed before the first load
    strobe_at(6, 16'h8001, 16'h7FFE);
    ucount = 0;
    for (int i = 0; i < 32; i++) begin
      guard = 0;
      prev  = bclk;
      tick();
      while (!(prev && !bclk) && guard < 4 * DIV) begin
        prev = bclk;
        tick();
        guard++;
      end
      chk("fall_time", 32'(n), 32'(2 * DIV * (i + 1)));
      chk("tab_sdata", 32'(sdata), 32'(tab[i].sd));
      chk("tab_lrck", 32'(lrck), 32'(tab[i].lr));
    end
    chk("first_frame_underrun", 32'(ucount), 32'(0));

    // Underrun: no new samples, frame repeats, one pulse per load
    for (int m = 1; m <= 2; m++) begin
      ucount = 0;
      capture(m, f);
      chk("repeat_frame", f, 32'h8001_7FFE);
      chk("underrun_per_load", 32'(ucount), 32'(1));
    end

    // Overrun: two strobes within one frame
    r1 = 16'($urandom);
    r2 = 16'($urandom);
    strobe_at(800, 16'h1111, r1);
    chk("overrun_first", 32'(overrun), 32'(0));
    strobe_at(850, 16'h2222, r2);
    chk("overrun_second", 32'(overrun), 32'(1));
    capture(4, f);
    chk("overrun_frame", f, {16'h2222, r2});

    // Simultaneous strobe and load
    r3 = 16'($urandom);
    r4 = 16'($urandom);
    strobe_at(1282, 16'h5555, r3);
    chk("pre_sim_overrun", 32'(overrun), 32'(0));
    strobe_at(2 * DIV * 161, 16'hAAAA, r4);
    chk("sim_overrun", 32'(overrun), 32'(0));
    chk("sim_underrun", 32'(underrun), 32'(0));
    capture(5, f);
    chk("sim_frame_old", f, {16'h5555, r3});
    ucount = 0;
    capture(6, f);
    chk("sim_frame_new", f, {16'hAAAA, r4});
    chk("sim_no_underrun", 32'(ucount), 32'(0));

    // Random strobes, checked only by the model
    for (int i = 0; i < 6 * 64 * DIV; i++) begin
      sample = ($urandom_range(0, 199) == 0);
      left   = 16'($urandom);
      right  = 16'($urandom);
      tick();
    end
    sample = 1'b0;

    // Mid-frame reset at slot 20
    k  = n / (2 * DIV);
    kk = k + 1;
    while (kk % 32 != 20) kk++;
    wait_until(2 * DIV * kk);
    chk("slot20_lrck", 32'(lrck), 32'(1));
    rst = 1'b1;
    tick();
    chk("midreset_outputs", 32'({bclk, lrck, sdata, overrun, underrun}), 32'(0));
    rst = 1'b0;
    check_restart("midreset");
    wait_until(2 * DIV);
    chk("midreset_underrun", 32'(underrun), 32'(1));
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
